sgd_tree_scheduler: RTL and testbench

Shares a single `TREE_WIDTH`-input signed adder tree between `NUM_REQ` bank requesters. Each requester streams dot-product beats of `TREE_WIDTH` partial products. The scheduler round-robin arbitrates the beats into the tree and tags every beat. It accumulates the tree's reduced sums per requester over `cfg_num_beats` beats and emits one finished dot product per requester burst through a result FIFO with valid/ready backpressure. It sits between the per-bank multiplier lanes and the gradient/update stage.

---
 rtl/sgd_tree_scheduler_if.sv | 25 ++
 rtl/sgd_tree_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sgd_tree_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_tree_scheduler_if.sv
// Requester beat and result handshakes for sgd_tree_scheduler.
// Slave side is the scheduler; master side is the requesters plus result consumer.
interface sgd_tree_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int TREE_WIDTH = 8,
   parameter int ID_W       = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [NUM_REQ-1:0][TREE_WIDTH-1:0][31:0] req_data;
   logic [31:0]                         res_data;
   logic [ID_W-1:0]                     res_id;
   logic                                res_valid;
   logic                                res_ready;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_data, res_id, res_valid
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_data, res_id, res_valid
   );
endinterface

// File: rtl/sgd_tree_scheduler.sv
// Round-robin sharing of one adder tree between bank requesters,
// with per-requester accumulation and a credited result FIFO.
module sgd_tree_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int TREE_WIDTH     = 8,
   parameter int TREE_LATENCY   = 2,
   parameter int RES_FIFO_DEPTH = 4,
   parameter int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                cfg_num_beats,
   sgd_tree_scheduler_if.slave        bus,
   output logic [TREE_WIDTH-1:0][31:0] tree_in,
   output logic                       tree_in_valid,
   input  logic [31:0]                tree_out,
   input  logic                       tree_out_valid,
   output logic                       busy,
   output logic                       err_orphan
);
   localparam int TD  = TREE_LATENCY + 2;
   localparam int TAW = $clog2(TD);
   localparam int TCW = $clog2(TD + 1);
   localparam int RAW = $clog2(RES_FIFO_DEPTH);
   localparam int RCW = RAW + 1;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            first;
      logic            last;
   } tag_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
   } res_t;

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [15:0]      beat_cnt_q [NUM_REQ];
   logic [15:0]      beat_cnt_d [NUM_REQ];
   logic [31:0]      acc_q [NUM_REQ];
   logic [31:0]      acc_d [NUM_REQ];
   logic [RCW-1:0]   lif_q, lif_d;
   tag_t             tag_mem_q [TD];
   tag_t             tag_mem_d [TD];
   logic [TAW-1:0]   tag_wr_q, tag_wr_d;
   logic [TAW-1:0]   tag_rd_q, tag_rd_d;
   logic [TCW-1:0]   tag_cnt_q, tag_cnt_d;
   res_t             res_mem_q [RES_FIFO_DEPTH];
   res_t             res_mem_d [RES_FIFO_DEPTH];
   logic [RAW-1:0]   res_wr_q, res_wr_d;
   logic [RAW-1:0]   res_rd_q, res_rd_d;
   logic [RCW-1:0]   res_cnt_q, res_cnt_d;
   logic [TREE_WIDTH-1:0][31:0] tree_in_q, tree_in_d;
   logic             tree_in_valid_q, tree_in_valid_d;
   logic             err_q, err_d;

   logic [15:0]        nb;
   logic [NUM_REQ-1:0] is_last;
   logic               credit_ok;
   logic               found;
   logic               xfer;
   logic               cnt_open;
   logic [ID_W-1:0]    gnt_id;
   logic [ID_W-1:0]    cand;
   tag_t               cur_tag;
   logic [31:0]        sum;
   logic               tag_pop;
   logic               res_push;
   logic               res_pop;

   // Last beats need a guaranteed FIFO slot; other beats always flow.
   always_comb begin : arb
      nb        = (cfg_num_beats == 16'd0) ? 16'd1 : cfg_num_beats;
      credit_ok = (int'(res_cnt_q) + int'(lif_q)) < RES_FIFO_DEPTH;
      cnt_open  = 1'b0;
      is_last   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         is_last[i] = beat_cnt_q[i] == nb - 16'd1;
         cnt_open   = cnt_open | (beat_cnt_q[i] != 16'd0);
      end
      found  = 1'b0;
      gnt_id = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand] &&
             (!is_last[cand] || credit_ok)) begin
            found  = 1'b1;
            gnt_id = cand;
         end
      end
      xfer          = found & rst_n;
      bus.req_ready = '0;
      if (xfer) bus.req_ready[gnt_id] = 1'b1;
   end

   always_comb begin : nxt
      ptr_d           = ptr_q;
      beat_cnt_d      = beat_cnt_q;
      acc_d           = acc_q;
      tag_mem_d       = tag_mem_q;
      tag_wr_d        = tag_wr_q;
      tag_rd_d        = tag_rd_q;
      res_mem_d       = res_mem_q;
      res_wr_d        = res_wr_q;
      res_rd_d        = res_rd_q;
      tree_in_d       = tree_in_q;
      tree_in_valid_d = xfer;
      err_d           = err_q;
      cur_tag         = tag_mem_q[tag_rd_q];
      tag_pop         = tree_out_valid && (tag_cnt_q != '0);
      sum             = cur_tag.first ? tree_out
                                      : acc_q[cur_tag.id] + tree_out;
      res_push        = tag_pop & cur_tag.last;
      res_pop         = bus.res_valid & bus.res_ready;
      if (tree_out_valid && (tag_cnt_q == '0)) err_d = 1'b1;
      if (xfer) begin
         tree_in_d  = bus.req_data[gnt_id];
         ptr_d      = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
         beat_cnt_d[gnt_id] = is_last[gnt_id] ? 16'd0
                                              : beat_cnt_q[gnt_id] + 16'd1;
         tag_mem_d[tag_wr_q] = '{id:    gnt_id,
                                 first: beat_cnt_q[gnt_id] == 16'd0,
                                 last:  is_last[gnt_id]};
         tag_wr_d = (int'(tag_wr_q) == TD - 1) ? '0 : tag_wr_q + 1'b1;
      end
      if (tag_pop) begin
         acc_d[cur_tag.id] = sum;
         tag_rd_d = (int'(tag_rd_q) == TD - 1) ? '0 : tag_rd_q + 1'b1;
      end
      tag_cnt_d = tag_cnt_q + TCW'(xfer) - TCW'(tag_pop);
      if (res_push) begin
         res_mem_d[res_wr_q] = '{id: cur_tag.id, data: sum};
         res_wr_d = res_wr_q + 1'b1;
      end
      if (res_pop) res_rd_d = res_rd_q + 1'b1;
      res_cnt_d = res_cnt_q + RCW'(res_push) - RCW'(res_pop);
      lif_d     = lif_q + RCW'(xfer & is_last[gnt_id]) - RCW'(res_push);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q           <= '0;
         lif_q           <= '0;
         tag_wr_q        <= '0;
         tag_rd_q        <= '0;
         tag_cnt_q       <= '0;
         res_wr_q        <= '0;
         res_rd_q        <= '0;
         res_cnt_q       <= '0;
         tree_in_q       <= '0;
         tree_in_valid_q <= 1'b0;
         err_q           <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            beat_cnt_q[i] <= '0;
            acc_q[i]      <= '0;
         end
      end else begin
         ptr_q           <= ptr_d;
         lif_q           <= lif_d;
         tag_wr_q        <= tag_wr_d;
         tag_rd_q        <= tag_rd_d;
         tag_cnt_q       <= tag_cnt_d;
         res_wr_q        <= res_wr_d;
         res_rd_q        <= res_rd_d;
         res_cnt_q       <= res_cnt_d;
         tree_in_q       <= tree_in_d;
         tree_in_valid_q <= tree_in_valid_d;
         err_q           <= err_d;
         beat_cnt_q      <= beat_cnt_d;
         acc_q           <= acc_d;
      end
   end

   // Storage only; validity is carried by the pointers and counts.
   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
      res_mem_q <= res_mem_d;
   end

   assign tree_in       = tree_in_q;
   assign tree_in_valid = tree_in_valid_q;
   assign err_orphan    = err_q;
   assign bus.res_valid = rst_n & (res_cnt_q != '0);
   assign bus.res_data  = bus.res_valid ? res_mem_q[res_rd_q].data : '0;
   assign bus.res_id    = bus.res_valid ? res_mem_q[res_rd_q].id : '0;
   assign busy = rst_n & ((tag_cnt_q != '0) | tree_in_valid_q | cnt_open |
                          (lif_q != '0) | (res_cnt_q != '0));
endmodule

// File: tb/tb_sgd_tree_scheduler.sv
// Bench for sgd_tree_scheduler: directed scenarios plus random traffic
// against a burst-level reference model with an ideal latency-2 tree.
module tb_sgd_tree_scheduler;
   localparam int NR  = 4;
   localparam int TW  = 8;
   localparam int L   = 2;
   localparam int DEP = 4;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [15:0]       cfg = 16'd1;
   logic [TW-1:0][31:0] tree_in;
   logic              tree_in_valid;
   logic [31:0]       tree_out;
   logic              tree_out_valid;
   logic              busy;
   logic              err_orphan;

   sgd_tree_scheduler_if #(.NUM_REQ(NR), .TREE_WIDTH(TW), .ID_W(IW)) bus ();

   sgd_tree_scheduler #(
      .NUM_REQ(NR), .TREE_WIDTH(TW), .TREE_LATENCY(L),
      .RES_FIFO_DEPTH(DEP), .ID_W(IW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_num_beats  (cfg),
      .bus            (bus.slave),
      .tree_in        (tree_in),
      .tree_in_valid  (tree_in_valid),
      .tree_out       (tree_out),
      .tree_out_valid (tree_out_valid),
      .busy           (busy),
      .err_orphan     (err_orphan)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lane_sum(input logic [TW-1:0][31:0] v);
      logic [31:0] s;
      s = 32'd0;
      for (int j = 0; j < TW; j++) s = s + v[j];
      return s;
   endfunction

   // Ideal tree: L-cycle pipeline, unaffected by the scheduler reset.
   logic [L-1:0] pv = '0;
   logic [31:0]  ps [L];
   always @(posedge clk) begin
      pv    <= {pv[L-2:0], tree_in_valid === 1'b1};
      ps[0] <= lane_sum(tree_in);
      for (int k = 1; k < L; k++) ps[k] <= ps[k-1];
   end
   assign tree_out_valid = pv[L-1];
   assign tree_out       = ps[L-1];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int          m_ptr;
   int          m_cnt [NR];
   logic [31:0] m_acc [NR];
   int          owed;
   int          exp_id [$];
   logic [31:0] exp_dat [$];
   int          glog [$];
   int          rlog_id [$];
   logic [31:0] rlog_dat [$];

   task automatic model_clear();
      m_ptr = 0;
      owed  = 0;
      for (int i = 0; i < NR; i++) begin
         m_cnt[i] = 0;
         m_acc[i] = 32'd0;
      end
      exp_id.delete();
      exp_dat.delete();
   endtask

   // One clock: predict the grant, check it, update the model, check pops.
   task automatic cyc();
      int nb, pred, ix;
      logic [NR-1:0] er, g;
      logic [31:0] s;
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
         model_clear();
      end else begin
         nb   = (cfg == 16'd0) ? 1 : int'(cfg);
         pred = -1;
         for (int k = 0; k < NR; k++) begin
            ix = (m_ptr + k) % NR;
            if (pred < 0 && bus.req_valid[ix] &&
                (m_cnt[ix] != nb - 1 || owed < DEP)) pred = ix;
         end
         er = '0;
         if (pred >= 0) er[pred] = 1'b1;
         chk("req_ready", 64'(bus.req_ready), 64'(er));
         g = bus.req_ready & bus.req_valid;
         for (int i = 0; i < NR; i++) if (g[i]) glog.push_back(i);
         if (pred >= 0) begin
            s = lane_sum(bus.req_data[pred]);
            m_acc[pred] = (m_cnt[pred] == 0) ? s : m_acc[pred] + s;
            if (m_cnt[pred] == nb - 1) begin
               exp_id.push_back(pred);
               exp_dat.push_back(m_acc[pred]);
               owed++;
               m_cnt[pred] = 0;
            end else begin
               m_cnt[pred]++;
            end
            m_ptr = (pred + 1) % NR;
         end
         if (bus.res_valid && bus.res_ready) begin
            rlog_id.push_back(int'(bus.res_id));
            rlog_dat.push_back(bus.res_data);
            chk("res_pending", 64'(exp_id.size() != 0), 64'd1);
            if (exp_id.size() != 0) begin
               chk("res_id", 64'(bus.res_id), 64'(exp_id[0]));
               chk("res_data", 64'(bus.res_data), 64'(exp_dat[0]));
               void'(exp_id.pop_front());
               void'(exp_dat.pop_front());
               owed--;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tree_in"}, 64'(|tree_in), 64'd0);
      chk({tag, "_tree_in_valid"}, 64'(tree_in_valid), 64'd0);
      chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
      chk({tag, "_res_data"}, 64'(bus.res_data), 64'd0);
      chk({tag, "_res_id"}, 64'(bus.res_id), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_err"}, 64'(err_orphan), 64'd0);
   endtask

   initial begin
      bus.req_valid = '1;
      bus.req_data  = '0;
      bus.res_ready = 1'b0;
      model_clear();
      // reset with requesters asserting valid
      repeat (2) cyc();
      chk("rst_req_ready_hold", 64'(bus.req_ready), 64'd0);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      bus.req_valid = '0;

      // single requester, one-beat burst, latency
      cfg = 16'd1;
      for (int j = 0; j < TW; j++) bus.req_data[0][j] = 32'd1;
      bus.req_valid = 4'b0001;
      cyc();
      bus.req_valid = '0;
      for (int n = 0; n < 4; n++) begin
         chk("lat_res_valid", 64'(bus.res_valid), 64'(n == 3));
         if (n < 3) cyc();
      end
      chk("basic_data", 64'(bus.res_data), 64'd8);
      chk("basic_id", 64'(bus.res_id), 64'd0);
      bus.res_ready = 1'b1;
      cyc();
      chk("basic_drained", 64'(bus.res_valid), 64'd0);

      // fair round-robin, four-beat bursts
      do_reset();
      cfg = 16'd4;
      for (int i = 0; i < NR; i++)
         for (int j = 0; j < TW; j++) bus.req_data[i][j] = 32'(i + 1);
      bus.req_valid = '1;
      glog.delete();
      rlog_id.delete();
      rlog_dat.delete();
      repeat (16) cyc();
      bus.req_valid = '0;
      repeat (8) cyc();
      chk("rr_grants", 64'(glog.size()), 64'd16);
      for (int k = 0; k < 16; k++)
         if (k < glog.size()) chk("rr_order", 64'(glog[k]), 64'(k % NR));
      chk("rr_results", 64'(rlog_id.size()), 64'd4);
      for (int k = 0; k < rlog_id.size(); k++) begin
         chk("rr_res_id", 64'(rlog_id[k]), 64'(k));
         chk("rr_res_data", 64'(rlog_dat[k]), 64'((k + 1) * 32));
      end

      // backpressure and credit
      cfg = 16'd1;
      bus.res_ready = 1'b0;
      bus.req_valid = '1;
      glog.delete();
      rlog_id.delete();
      rlog_dat.delete();
      repeat (10) cyc();
      chk("bp_grants", 64'(glog.size()), 64'd4);
      chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
      chk("bp_fifo_full", 64'(bus.res_valid), 64'd1);
      bus.res_ready = 1'b1;
      repeat (10) cyc();
      chk("bp_resume", 64'(glog.size() > 4), 64'd1);
      for (int k = 0; k < 4; k++)
         if (k < rlog_id.size() && k < glog.size())
            chk("bp_drain_order", 64'(rlog_id[k]), 64'(glog[k]));
      bus.req_valid = '0;
      repeat (8) cyc();

      // two's complement wrap across a two-beat burst
      cfg = 16'd2;
      bus.req_data = '0;
      bus.req_data[2][0] = 32'h7FFF_FFFF;
      bus.req_data[2][1] = 32'd1;
      bus.req_valid = 4'b0100;
      rlog_id.delete();
      rlog_dat.delete();
      repeat (2) cyc();
      bus.req_valid = '0;
      repeat (8) cyc();
      chk("wrap_results", 64'(rlog_dat.size()), 64'd1);
      if (rlog_dat.size() != 0) begin
         chk("wrap_data", 64'(rlog_dat[0]), 64'd0);
         chk("wrap_id", 64'(rlog_id[0]), 64'd2);
      end
      chk("wrap_err", 64'(err_orphan), 64'd0);
      chk("wrap_idle", 64'(busy), 64'd0);

      // random traffic, burst length 3 then 0 (treated as 1)
      for (int p = 0; p < 2; p++) begin
         do_reset();
         cfg = (p == 0) ? 16'd3 : 16'd0;
         repeat (250) begin
            bus.req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++)
               for (int j = 0; j < TW; j++) bus.req_data[i][j] = $urandom;
            bus.res_ready = ($urandom % 4) != 0;
            cyc();
         end
         bus.req_valid = '0;
         bus.res_ready = 1'b1;
         repeat (12) cyc();
         chk("rand_drained", 64'(exp_id.size()), 64'd0);
         chk("rand_err", 64'(err_orphan), 64'd0);
      end

      // reset while beats are inside the tree
      do_reset();
      cfg = 16'd2;
      for (int j = 0; j < TW; j++) bus.req_data[0][j] = 32'd5;
      bus.req_valid = 4'b0001;
      repeat (2) cyc();
      bus.req_valid = '0;
      do_reset();
      chk_reset_outputs("midrst");
      rlog_id.delete();
      rlog_dat.delete();
      repeat (4) cyc();
      chk("orphan_set", 64'(err_orphan), 64'd1);
      chk("orphan_no_result", 64'(rlog_dat.size()), 64'd0);
      for (int j = 0; j < TW; j++) bus.req_data[1][j] = 32'd2;
      bus.req_valid = 4'b0010;
      repeat (2) cyc();
      bus.req_valid = '0;
      repeat (8) cyc();
      chk("post_rst_results", 64'(rlog_dat.size()), 64'd1);
      if (rlog_dat.size() != 0) begin
         chk("post_rst_data", 64'(rlog_dat[0]), 64'd32);
         chk("post_rst_id", 64'(rlog_id[0]), 64'd1);
      end
      chk("orphan_sticky", 64'(err_orphan), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
